// File: rtl/mem_responder_if.sv
// mem_responder_if: request/response bundle between the core's memory port
// (master) and the memory responder (slave).
//   req    master->slave  request strobe, sampled only while the responder is idle
//   we     master->slave  1 = write, 0 = read
//   addr   master->slave  32-bit byte address
//   wdata  master->slave  write data
//   ready  slave->master  one-cycle response pulse
//   rdata  slave->master  read data, held until the next read response
//   busy   slave->master  transaction in flight (accept+1 .. ready cycle)
//   err    slave->master  misaligned-access flag, valid with ready
interface mem_responder_if #(
    parameter int DATA_W = 32
);
    logic              req;
    logic              we;
    logic [31:0]       addr;
    logic [DATA_W-1:0] wdata;
    logic              ready;
    logic [DATA_W-1:0] rdata;
    logic              busy;
    logic              err;

    modport master (
        output req, we, addr, wdata,
        input  ready, rdata, busy, err
    );

    modport slave (
        input  req, we, addr, wdata,
        output ready, rdata, busy, err
    );
endinterface

// File: rtl/mem_responder.sv
// mem_responder: word-wide memory behind a fixed-latency request/ready
// handshake, so the multicycle control FSM sees realistic wait states.
//
// Ports:
//   clk    rising-edge clock
//   reset  synchronous, active-high reset (control and output registers only;
//          memory contents survive reset)
//   bus    mem_responder_if.slave (req/we/addr/wdata in; ready/rdata/busy/err out)
//
// Parameters:
//   ADDR_W       word-address width, depth = 2**ADDR_W words
//   DATA_W       data word width
//   WAIT_CYCLES  wait states between accept and ready (0..15)
//
// Optional feature macro: MEM_RESPONDER_ALIGN_CHECK_EN
//   defined   -> misaligned accesses (addr[1:0] != 0) are suppressed and flagged
//                with err alongside ready
//   undefined -> addr[1:0] ignored, err tied low
module mem_responder #(
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 32,
    parameter int WAIT_CYCLES = 2
) (
    input  logic           clk,
    input  logic           reset,
    mem_responder_if.slave bus
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

    logic [1:0]        state_q;
    logic [1:0]        state_d;
    logic [3:0]        cnt_q;
    logic [3:0]        cnt_d;
    logic              commit;

    // Request fields captured at accept.
    logic              we_p0;
    logic [ADDR_W+1:0] addr_p0;
    logic [DATA_W-1:0] wdata_p0;

    // Fields of the transaction being committed this edge. With zero wait
    // states the commit edge is the accept edge, so the live bus inputs are
    // used; otherwise the captured copy is.
    logic              c_we;
    logic [ADDR_W+1:0] c_addr;
    logic [DATA_W-1:0] c_wdata;
    logic [ADDR_W-1:0] c_idx;
    logic              c_bad;

    logic [DATA_W-1:0] mem [2**ADDR_W];

    logic              unused_addr;

    assign c_we    = (state_q == S_IDLE) ? bus.we                : we_p0;
    assign c_addr  = (state_q == S_IDLE) ? bus.addr[ADDR_W+1:0]  : addr_p0;
    assign c_wdata = (state_q == S_IDLE) ? bus.wdata             : wdata_p0;
    assign c_idx   = c_addr[ADDR_W+1:2];

`ifdef MEM_RESPONDER_ALIGN_CHECK_EN
    assign c_bad       = (c_addr[1:0] != 2'b00);
    assign unused_addr = ^bus.addr[31:ADDR_W+2];
`else
    assign c_bad       = 1'b0;
    assign unused_addr = ^{bus.addr[31:ADDR_W+2], c_addr[1:0]};
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        commit  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.req) begin
                    if (WAIT_CYCLES == 0) begin
                        state_d = S_RESP;
                        cnt_d   = 4'd0;
                        commit  = 1'b1;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = WAIT_INIT;
                    end
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = S_RESP;
                    commit  = 1'b1;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // Control state and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= 4'd0;
            bus.ready <= 1'b0;
            bus.busy  <= 1'b0;
            bus.err   <= 1'b0;
            bus.rdata <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bus.ready <= (state_d == S_RESP);
            bus.busy  <= (state_d != S_IDLE);
            bus.err   <= commit & c_bad;
            if (commit && !c_we && !c_bad) begin
                bus.rdata <= mem[c_idx];
            end
        end
    end

    // Request capture; only meaningful for transactions that survive to commit.
    always_ff @(posedge clk) begin
        if (state_q == S_IDLE && bus.req) begin
            we_p0    <= bus.we;
            addr_p0  <= bus.addr[ADDR_W+1:0];
            wdata_p0 <= bus.wdata;
        end
    end

    // Storage: reset only gates the write so an aborted write is never committed.
    always_ff @(posedge clk) begin
        if (!reset && commit && c_we && !c_bad) begin
            mem[c_idx] <= c_wdata;
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: directed plus randomized bench for mem_responder.
// Main instance runs with WAIT_CYCLES=2, a second with WAIT_CYCLES=0.
// Expected values come from a word-indexed reference memory in the bench.
module tb_mem_responder;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 32;
    localparam int WAIT_N = 2;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    mem_responder_if #(.DATA_W(DATA_W)) bus  ();
    mem_responder_if #(.DATA_W(DATA_W)) bus0 ();

    mem_responder #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .WAIT_CYCLES(WAIT_N)
    ) dut (
        .clk(clk), .reset(reset), .bus(bus.slave)
    );

    mem_responder #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .WAIT_CYCLES(0)
    ) dut0 (
        .clk(clk), .reset(reset), .bus(bus0.slave)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: word index -> contents, plus the expected rdata.
    logic [31:0] ref_mem [int];
    logic [31:0] ref_rdata;
    bit          rdata_known;

    function automatic bit misaligned(input logic [31:0] a);
`ifdef MEM_RESPONDER_ALIGN_CHECK_EN
        return (a % 32'd4) != 32'd0;
`else
        return 1'b0;
`endif
    endfunction

    // Byte address wraps modulo 4 * 2**ADDR_W, then selects a word.
    function automatic int widx(input logic [31:0] a);
        return int'((a % 32'd1024) / 32'd4);
    endfunction

    task automatic model_apply(input logic w, input logic [31:0] a, input logic [31:0] d);
        if (!misaligned(a)) begin
            if (w) begin
                ref_mem[widx(a)] = d;
            end else if (ref_mem.exists(widx(a))) begin
                ref_rdata   = ref_mem[widx(a)];
                rdata_known = 1'b1;
            end else begin
                rdata_known = 1'b0;
            end
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One transaction on the WAIT_N instance. Entered and left #1 after a
    // rising edge in an idle cycle. With hold=1, req stays high and the other
    // inputs are scrambled after accept; the caller drops req when done.
    task automatic txn(input logic w, input logic [31:0] a, input logic [31:0] d,
                       input bit hold, input string tag);
        bit exp_err;
        bus.req   = 1'b1;
        bus.we    = w;
        bus.addr  = a;
        bus.wdata = d;
        exp_err   = misaligned(a);
        model_apply(w, a, d);
        for (int i = 0; i <= WAIT_N; i++) begin
            @(posedge clk); #1;
            if (hold) begin
                bus.we    = 1'($urandom);
                bus.addr  = $urandom;
                bus.wdata = $urandom;
            end else begin
                bus.req = 1'b0;
            end
            check({tag, "_busy"}, 32'(bus.busy), 32'd1);
            check({tag, "_ready"}, 32'(bus.ready), (i == WAIT_N) ? 32'd1 : 32'd0);
            if (i == WAIT_N) begin
                check({tag, "_err"}, 32'(bus.err), 32'(exp_err));
                if (rdata_known) check({tag, "_rdata"}, bus.rdata, ref_rdata);
            end
        end
        @(posedge clk); #1;
        check({tag, "_idle_busy"}, 32'(bus.busy), 32'd0);
        check({tag, "_idle_ready"}, 32'(bus.ready), 32'd0);
        check({tag, "_idle_err"}, 32'(bus.err), 32'd0);
        if (rdata_known) check({tag, "_idle_rdata"}, bus.rdata, ref_rdata);
    endtask

    // One transaction on the zero-wait instance: ready exactly one cycle after accept.
    task automatic txn0(input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [31:0] exp_rdata, input string tag);
        bus0.req   = 1'b1;
        bus0.we    = w;
        bus0.addr  = a;
        bus0.wdata = d;
        @(posedge clk); #1;
        bus0.req = 1'b0;
        check({tag, "_ready"}, 32'(bus0.ready), 32'd1);
        check({tag, "_busy"}, 32'(bus0.busy), 32'd1);
        check({tag, "_rdata"}, bus0.rdata, exp_rdata);
        @(posedge clk); #1;
        check({tag, "_idle_ready"}, 32'(bus0.ready), 32'd0);
        check({tag, "_idle_busy"}, 32'(bus0.busy), 32'd0);
    endtask

    initial begin
        logic [31:0] r;
        logic [7:0]  idx;
        logic [1:0]  lo;

        bus.req = 1'b0;  bus.we = 1'b0;  bus.addr = '0;  bus.wdata = '0;
        bus0.req = 1'b0; bus0.we = 1'b0; bus0.addr = '0; bus0.wdata = '0;

        // Reset held for two cycles with a write request pending.
        reset     = 1'b1;
        bus.req   = 1'b1;
        bus.we    = 1'b1;
        bus.addr  = 32'h10;
        bus.wdata = 32'hFFFF_FFFF;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            check("rst_ready", 32'(bus.ready), 32'd0);
            check("rst_busy", 32'(bus.busy), 32'd0);
            check("rst_err", 32'(bus.err), 32'd0);
            check("rst_rdata", bus.rdata, 32'd0);
        end
        bus.req = 1'b0;
        reset   = 1'b0;
        ref_rdata   = 32'd0;
        rdata_known = 1'b1;
        @(posedge clk); #1;
        check("post_rst_busy", 32'(bus.busy), 32'd0);

        // Write then read back; write leaves rdata at 0.
        txn(1'b1, 32'h10, 32'hDEAD_BEEF, 1'b0, "wr10");
        txn(1'b0, 32'h10, 32'h0, 1'b0, "rd10");

        // Held request: accepts every WAIT_N+2 cycles, inputs scrambled mid-flight.
        txn(1'b1, 32'h40, 32'hA0A0_0001, 1'b1, "hold_wr40");
        txn(1'b1, 32'h44, 32'hA0A0_0002, 1'b1, "hold_wr44");
        txn(1'b0, 32'h44, 32'h0, 1'b1, "hold_rd44");
        txn(1'b0, 32'h40, 32'h0, 1'b1, "hold_rd40");
        bus.req = 1'b0;

        // Address wrap: 0x400 aliases word 0.
        txn(1'b1, 32'h400, 32'h1111_1111, 1'b0, "wrap_wr");
        txn(1'b0, 32'h000, 32'h0, 1'b0, "wrap_rd");

        // Zero wait states.
        txn0(1'b1, 32'h400, 32'h1111_1111, 32'h0, "w0_wr");
        txn0(1'b0, 32'h000, 32'h0, 32'h1111_1111, "w0_rd");
        txn0(1'b1, 32'h8, 32'h0000_CAFE, 32'h1111_1111, "w0_wr8");
        txn0(1'b0, 32'h408, 32'h0, 32'h0000_CAFE, "w0_rd408");

        // Reset during the first wait cycle aborts the write.
        txn(1'b1, 32'h20, 32'h7, 1'b0, "wr20");
        bus.req   = 1'b1;
        bus.we    = 1'b1;
        bus.addr  = 32'h20;
        bus.wdata = 32'h5;
        @(posedge clk); #1;
        bus.req = 1'b0;
        check("abort_busy", 32'(bus.busy), 32'd1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        ref_rdata   = 32'd0;
        rdata_known = 1'b1;
        check("abort_rdata", bus.rdata, 32'd0);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            check("abort_no_ready", 32'(bus.ready), 32'd0);
            check("abort_no_busy", 32'(bus.busy), 32'd0);
        end
        txn(1'b0, 32'h20, 32'h0, 1'b0, "rd20_after_abort");

        // Alignment: misaligned write to the word at 0x10.
        txn(1'b1, 32'h10, 32'h0, 1'b0, "align_clear");
        txn(1'b1, 32'h13, 32'hAA, 1'b0, "align_wr13");
        txn(1'b0, 32'h10, 32'h0, 1'b0, "align_rd10");

        // Randomized: seed words 0..15, then mixed traffic with random upper
        // and low address bits.
        for (int i = 0; i < 16; i++) begin
            txn(1'b1, 32'(i * 4), $urandom, 1'b0, "seed");
        end
        for (int i = 0; i < 24; i++) begin
            r   = $urandom;
            idx = 8'($urandom_range(0, 15));
            lo  = 2'($urandom_range(0, 3));
            txn(1'($urandom), {r[31:10], idx, lo}, $urandom, 1'(i % 2), "rand");
            bus.req = 1'b0;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global time bound so the bench always terminates.
    initial begin
        #200000;
        failures++;
        $display("FAIL timeout observed=running expected=finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
